// File: rtl/sysid_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sysid_rr_arbiter
// Purpose  : Round-robin read arbiter that lets several Avalon-MM read masters
//            share one fixed-latency, no-waitrequest read-only slave (for
//            example the system-ID slave). At most one read is accepted per
//            cycle. Accepted reads go onto the single slave port, and the
//            returning data is routed back to the master that issued the read.
//
// Parameters:
//   NUM_MASTERS   number of requesting masters (2..8)
//   ADDR_W        slave word-address width
//   DATA_W        data width
//   SLAVE_LATENCY fixed slave read latency in cycles (0..3), where 0 means
//                 s_readdata is combinational from s_address
//
// Ports:
//   clock            in   rising-edge clock
//   reset            in   asynchronous active-high reset
//   m_read           in   per-master read request, held until accepted
//   m_address        in   per-master address, master i at [i*ADDR_W +: ADDR_W]
//   m_waitrequest    out  per-master stall; low means accepted this cycle
//   m_readdata       out  shared return data, held between returns
//   m_readdatavalid  out  one-hot return strobe
//   s_read           out  read strobe to slave
//   s_address        out  address to slave (zero when idle)
//   s_readdata       in   slave return data
//
// Revision : 1.0  initial release
// ============================================================================
module sysid_rr_arbiter #(
  parameter int NUM_MASTERS   = 4,
  parameter int ADDR_W        = 1,
  parameter int DATA_W        = 32,
  parameter int SLAVE_LATENCY = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  output logic [NUM_MASTERS-1:0]        m_waitrequest,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [NUM_MASTERS-1:0]        m_readdatavalid,
  output logic                          s_read,
  output logic [ADDR_W-1:0]             s_address,
  input  logic [DATA_W-1:0]             s_readdata
);

  localparam int               IDX_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  // --------------------------------------------------------------------------
  // Grant selection
  // --------------------------------------------------------------------------
  logic [NUM_MASTERS-1:0] w_req;
  logic [NUM_MASTERS-1:0] w_grant;
  logic                   w_accept;
  logic [IDX_W-1:0]       w_grant_idx;
  logic [IDX_W-1:0]       last_grant_q;
  logic [IDX_W-1:0]       last_grant_d;

  // Requests are masked during reset. This keeps waitrequest high and the
  // slave idle even while the masters are still driving m_read.
  assign w_req = m_read & {NUM_MASTERS{~reset}};

  // Rotating priority search. The search starts at the master after the last
  // winner and wraps around, so the last winner is checked last. Only the
  // first hit is taken, which keeps the grant one-hot or zero.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand        = 0;
    cand_idx    = '0;
    w_grant     = '0;
    w_grant_idx = '0;
    w_accept    = 1'b0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      cand     = (int'(last_grant_q) + off) % NUM_MASTERS;
      cand_idx = IDX_W'(cand);
      if (!w_accept && w_req[cand_idx]) begin
        w_accept          = 1'b1;
        w_grant_idx       = cand_idx;
        w_grant[cand_idx] = 1'b1;
      end
    end
  end

  assign last_grant_d  = w_accept ? w_grant_idx : last_grant_q;
  assign m_waitrequest = ~w_grant;
  assign s_read        = w_accept;

  // The address mux uses the one-hot grant directly. This gives zero when
  // no master is granted.
  always_comb begin
    s_address = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_grant[i]) begin
        s_address = m_address[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Return pipeline
  // Stage 0 is loaded with {valid, master} when a read is accepted, and the
  // entry then moves down one stage per cycle. The slave drives the data
  // while the entry is moving into the last stage (stage SLAVE_LATENCY), so
  // the data is captured on that same edge. The return strobe is then
  // decoded from the last stage, which places it SLAVE_LATENCY+1 cycles
  // after acceptance.
  // --------------------------------------------------------------------------
  logic [SLAVE_LATENCY:0] pipe_v_q;
  logic [SLAVE_LATENCY:0] pipe_v_d;
  logic [IDX_W-1:0]       pipe_idx_q [SLAVE_LATENCY+1];
  logic [IDX_W-1:0]       pipe_idx_d [SLAVE_LATENCY+1];
  logic [DATA_W-1:0]      rdata_q;
  logic [DATA_W-1:0]      rdata_d;

  always_comb begin
    pipe_v_d[0]   = w_accept;
    pipe_idx_d[0] = w_grant_idx;
    for (int k = 1; k <= SLAVE_LATENCY; k++) begin
      pipe_v_d[k]   = pipe_v_q[k-1];
      pipe_idx_d[k] = pipe_idx_q[k-1];
    end
  end

  // m_readdata only changes on a return. Otherwise it holds the last value.
  assign rdata_d = pipe_v_d[SLAVE_LATENCY] ? s_readdata : rdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q <= LAST_IDX;
      pipe_v_q     <= '0;
      rdata_q      <= '0;
      for (int k = 0; k <= SLAVE_LATENCY; k++) begin
        pipe_idx_q[k] <= '0;
      end
    end else begin
      last_grant_q <= last_grant_d;
      pipe_v_q     <= pipe_v_d;
      rdata_q      <= rdata_d;
      for (int k = 0; k <= SLAVE_LATENCY; k++) begin
        pipe_idx_q[k] <= pipe_idx_d[k];
      end
    end
  end

  always_comb begin
    m_readdatavalid = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_readdatavalid[i] = pipe_v_q[SLAVE_LATENCY] &&
                           (pipe_idx_q[SLAVE_LATENCY] == IDX_W'(i));
    end
  end

  assign m_readdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sysid_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sysid_rr_arbiter
// Purpose  : Self-checking bench for sysid_rr_arbiter. Three instances are
//            built, with slave latency 0, 2 and 3. Each instance has its own
//            fixed-latency slave model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sysid_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    mrd   [3];
  logic [N*AW-1:0] madr  [3];
  logic [N-1:0]    wr    [3];
  logic [N-1:0]    rdv   [3];
  logic [DW-1:0]   rdat  [3];
  logic [DW-1:0]   srdat [3];
  logic            srd   [3];
  logic [AW-1:0]   sadr  [3];
  logic [AW-1:0]   sl2   [2];
  logic [AW-1:0]   sl3   [3];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          due;
    int          m;
    logic [31:0] data;
  } ret_t;

  function automatic logic [31:0] slave_word(input logic [AW-1:0] a);
    case (a)
      2'd0:    return 32'h0000_0000;
      2'd1:    return 32'h694B_C90D;
      2'd2:    return 32'h1357_9BDF;
      default: return 32'h2468_ACE0;
    endcase
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  sysid_rr_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .SLAVE_LATENCY(0)) u_dut0 (
    .clock(clk), .reset(rst), .m_read(mrd[0]), .m_address(madr[0]),
    .m_waitrequest(wr[0]), .m_readdata(rdat[0]), .m_readdatavalid(rdv[0]),
    .s_read(srd[0]), .s_address(sadr[0]), .s_readdata(srdat[0]));

  sysid_rr_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .SLAVE_LATENCY(2)) u_dut2 (
    .clock(clk), .reset(rst), .m_read(mrd[1]), .m_address(madr[1]),
    .m_waitrequest(wr[1]), .m_readdata(rdat[1]), .m_readdatavalid(rdv[1]),
    .s_read(srd[1]), .s_address(sadr[1]), .s_readdata(srdat[1]));

  sysid_rr_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .SLAVE_LATENCY(3)) u_dut3 (
    .clock(clk), .reset(rst), .m_read(mrd[2]), .m_address(madr[2]),
    .m_waitrequest(wr[2]), .m_readdata(rdat[2]), .m_readdatavalid(rdv[2]),
    .s_read(srd[2]), .s_address(sadr[2]), .s_readdata(srdat[2]));

  // Fixed-latency slaves: data for the address seen in cycle T is presented in T+LAT.
  assign srdat[0] = slave_word(sadr[0]);
  always @(posedge clk) begin
    sl2[0] <= sadr[1];
    sl2[1] <= sl2[0];
    sl3[0] <= sadr[2];
    sl3[1] <= sl3[0];
    sl3[2] <= sl3[1];
  end
  assign srdat[1] = slave_word(sl2[1]);
  assign srdat[2] = slave_word(sl3[2]);

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      mrd[d]  = '0;
      madr[d] = '0;
    end
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      mrd[d]  = '1;
      madr[d] = '0;
    end
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (wr[d] !== 4'hF || srd[d] !== 1'b0 || rdv[d] !== 4'h0 || rdat[d] !== 32'h0) begin
          failures++;
          $display("FAIL reset_state dut%0d: wr=%b s_read=%b rdv=%b rdata=%h, required wr=1111 s_read=0 rdv=0000 rdata=0",
                   d, wr[d], srd[d], rdv[d], rdat[d]);
        end
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (wr[d] !== 4'b1110) begin
        failures++;
        $display("FAIL first_grant dut%0d: wr=%b required 1110", d, wr[d]);
      end
    end
    next_cycle();
    for (int d = 0; d < 3; d++) mrd[d] = '0;
  endtask

  task automatic test_single;
    do_reset();
    madr[0] = 8'h10;            // master 2 -> address 1
    mrd[0]  = 4'b0100;
    @(negedge clk);
    checks++;
    if (wr[0] !== 4'b1011 || srd[0] !== 1'b1 || sadr[0] !== 2'd1) begin
      failures++;
      $display("FAIL single_accept: wr=%b s_read=%b s_addr=%0d required wr=1011 s_read=1 s_addr=1",
               wr[0], srd[0], sadr[0]);
    end
    next_cycle();
    mrd[0] = '0;
    @(negedge clk);
    checks++;
    if (rdv[0] !== 4'b0100 || rdat[0] !== 32'h694BC90D) begin
      failures++;
      $display("FAIL single_return: rdv=%b rdata=%h required rdv=0100 rdata=694bc90d", rdv[0], rdat[0]);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rdv[0] !== 4'b0000 || rdat[0] !== 32'h694BC90D) begin
      failures++;
      $display("FAIL single_hold: rdv=%b rdata=%h required rdv=0000 rdata=694bc90d", rdv[0], rdat[0]);
    end
    next_cycle();
  endtask

  task automatic test_round_robin;
    logic [AW-1:0] prev_a;
    logic [N-1:0]  exp_wr;
    logic [N-1:0]  exp_rdv;
    int            g;
    do_reset();
    madr[0] = N*AW'($urandom);
    mrd[0]  = '1;
    prev_a  = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      g      = k % N;
      exp_wr = ~(N'(1) << g);
      checks++;
      if (wr[0] !== exp_wr) begin
        failures++;
        $display("FAIL rr_grant cycle%0d: wr=%b required %b", k, wr[0], exp_wr);
      end
      exp_rdv = (k == 0) ? '0 : (N'(1) << ((k - 1) % N));
      checks++;
      if (rdv[0] !== exp_rdv || (k > 0 && rdat[0] !== slave_word(prev_a))) begin
        failures++;
        $display("FAIL rr_return cycle%0d: rdv=%b rdata=%h required rdv=%b rdata=%h",
                 k, rdv[0], rdat[0], exp_rdv, slave_word(prev_a));
      end
      prev_a = madr[0][g*AW +: AW];
      next_cycle();
      madr[0][g*AW +: AW] = AW'($urandom);
    end
    mrd[0] = '0;
  endtask

  task automatic test_back_to_back;
    logic [N-1:0]  exp_wr  [5];
    logic [N-1:0]  exp_rdv [5];
    logic [31:0]   exp_dat [5];
    exp_wr  = '{4'b1101, 4'b0111, 4'b1111, 4'b1111, 4'b1111};
    exp_rdv = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b1000};
    exp_dat = '{32'h0, 32'h0, 32'h0, 32'h1357_9BDF, 32'h2468_ACE0};
    do_reset();
    madr[1] = 8'b11_00_10_00;   // master 1 -> addr 2, master 3 -> addr 3
    mrd[1]  = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (wr[1] !== exp_wr[k] || rdv[1] !== exp_rdv[k] || rdat[1] !== exp_dat[k]) begin
        failures++;
        $display("FAIL b2b_lat2 T+%0d: wr=%b rdv=%b rdata=%h required wr=%b rdv=%b rdata=%h",
                 k, wr[1], rdv[1], rdat[1], exp_wr[k], exp_rdv[k], exp_dat[k]);
      end
      next_cycle();
      mrd[1] = (k == 0) ? 4'b1000 : 4'b0000;
    end
  endtask

  task automatic test_fairness_wrap;
    logic [N-1:0] reqs   [3];
    logic [N-1:0] exp_wr [3];
    reqs   = '{4'b1000, 4'b1001, 4'b1001};
    exp_wr = '{4'b0111, 4'b1110, 4'b0111};
    do_reset();
    madr[0] = 8'b01_00_00_01;
    for (int k = 0; k < 3; k++) begin
      mrd[0] = reqs[k];
      @(negedge clk);
      checks++;
      if (wr[0] !== exp_wr[k]) begin
        failures++;
        $display("FAIL fair_wrap step%0d: wr=%b required %b", k, wr[0], exp_wr[k]);
      end
      next_cycle();
    end
    mrd[0] = '0;
  endtask

  task automatic test_reset_midflight;
    do_reset();
    madr[2] = 8'h02;
    mrd[2]  = 4'b0001;
    @(negedge clk);
    checks++;
    if (wr[2] !== 4'b1110) begin
      failures++;
      $display("FAIL midflight_accept: wr=%b required 1110", wr[2]);
    end
    next_cycle();
    mrd[2] = '0;
    rst    = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (rdv[2] !== 4'b0000 || rdat[2] !== 32'h0) begin
        failures++;
        $display("FAIL midflight_discard cycle%0d: rdv=%b rdata=%h required rdv=0000 rdata=0",
                 k, rdv[2], rdat[2]);
      end
      next_cycle();
    end
  endtask

  // Random traffic checked against a queue-based model: rotating-priority
  // winner, returns due LAT+1 cycles after acceptance, in acceptance order.
  task automatic test_random(input int d);
    int            lat;
    int            lp;
    int            win;
    int            c;
    int            waitc [N];
    logic [N-1:0]  req;
    logic [AW-1:0] addr [N];
    logic [N-1:0]  exp_wr;
    logic [N-1:0]  exp_rdv;
    logic [AW-1:0] exp_sa;
    logic [31:0]   exp_dat;
    logic [31:0]   last_data;
    ret_t          q [$];
    lat       = lat_of(d);
    lp        = N - 1;
    req       = '0;
    last_data = '0;
    for (int i = 0; i < N; i++) begin
      waitc[i] = 0;
      addr[i]  = '0;
    end
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      mrd[d] = req;
      for (int i = 0; i < N; i++) madr[d][i*AW +: AW] = addr[i];
      @(negedge clk);
      win = -1;
      for (int off = 1; off <= N; off++) begin
        c = (lp + off) % N;
        if (win < 0 && req[c]) win = c;
      end
      exp_wr = '1;
      exp_sa = '0;
      if (win >= 0) begin
        exp_wr[win] = 1'b0;
        exp_sa      = addr[win];
      end
      checks++;
      if (wr[d] !== exp_wr || srd[d] !== (win >= 0) || sadr[d] !== exp_sa) begin
        failures++;
        $display("FAIL rand_grant dut%0d cycle%0d: wr=%b s_read=%b s_addr=%0d required wr=%b s_read=%0d s_addr=%0d",
                 d, cyc, wr[d], srd[d], sadr[d], exp_wr, (win >= 0), exp_sa);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_rdv   = N'(1) << q[0].m;
        exp_dat   = q[0].data;
        last_data = exp_dat;
        void'(q.pop_front());
      end else begin
        exp_rdv = '0;
        exp_dat = last_data;
      end
      checks++;
      if (rdv[d] !== exp_rdv || rdat[d] !== exp_dat) begin
        failures++;
        $display("FAIL rand_return dut%0d cycle%0d: rdv=%b rdata=%h required rdv=%b rdata=%h",
                 d, cyc, rdv[d], rdat[d], exp_rdv, exp_dat);
      end
      if (win >= 0) begin
        q.push_back('{due: cyc + lat + 1, m: win, data: slave_word(addr[win])});
        lp = win;
      end
      for (int i = 0; i < N; i++) begin
        if (req[i] && i != win) begin
          waitc[i]++;
          checks++;
          if (waitc[i] > N - 1) begin
            failures++;
            $display("FAIL rand_fairness dut%0d cycle%0d master%0d: waited %0d cycles, required at most %0d",
                     d, cyc, i, waitc[i], N - 1);
          end
        end else begin
          waitc[i] = 0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (cyc >= 380) begin
          req[i] = 1'b0;
        end else if (i == win || !req[i]) begin
          req[i]  = ($urandom_range(0, 2) != 0);
          addr[i] = AW'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;        // master gives up while stalled
        end
        if (!req[i]) waitc[i] = 0;
      end
      next_cycle();
    end
    mrd[d] = '0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      mrd[d]  = '0;
      madr[d] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_fairness_wrap();
    test_reset_midflight();
    test_random(0);
    test_random(1);
    test_random(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, required completion before 1000000 time units");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
